// File: rtl/trace_chk_pkg.sv
// Shared types and helpers for the commit-trace checker.
package trace_chk_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned POP_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  wdata;
  } commit_entry_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    HALT = 2'd2
  } chk_state_e;

  function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/trace_commit_fifo.sv
// Multi-write, single-read commit FIFO; valid lanes are packed in lane order and
// lanes beyond the free space are dropped (drop_c).
module trace_commit_fifo
  import trace_chk_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LANES-1:0]           wr_valid,
  input  commit_entry_t [LANES-1:0]  wr_data,
  input  logic                       rd_en,
  output commit_entry_t              head_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full_c,
  output logic [$clog2(DEPTH):0]     free_c,
  output logic                       drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  commit_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] push_cnt;
  logic [LANES-1:0] lane_we;
  logic [PTR_W-1:0] lane_addr [LANES];

  assign free_c = CNT_W'(DEPTH) - count;
  assign full_c = (count == CNT_W'(DEPTH));
  assign head_c = mem[rd_ptr];

  // Slot assignment: each accepted lane takes the next consecutive tail slot.
  always_comb begin
    push_cnt = '0;
    drop_c   = 1'b0;
    lane_we  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = wr_ptr + PTR_W'(push_cnt);
      if (wr_valid[i]) begin
        if (push_cnt < free_c) begin
          lane_we[i] = 1'b1;
          push_cnt   = push_cnt + CNT_W'(1);
        end else begin
          drop_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + push_cnt - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) mem[lane_addr[i]] <= wr_data[i];
    end
  end

endmodule

// File: rtl/commit_trace_checker.sv
// N-lane commit-trace checker against a streamed golden trace.
// Optional TRACE_CHK_HALT_ON_ERR_EN: first mismatch halts checking and adds halt_o.
module commit_trace_checker
  import trace_chk_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] SKIP_BASE = 32'hbfc00380,
  parameter logic [31:0] SKIP_MASK = 32'hfffffff8,
  parameter logic [31:0] END_PC    = 32'hbfc00100
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LANES-1:0]         wb_en,
  input  logic [REG_W*LANES-1:0]   wb_rd,
  input  logic [XLEN*LANES-1:0]    wb_wdata,
  input  logic [XLEN*LANES-1:0]    wb_pc,
  input  logic                     ref_valid,
  output logic                     ref_ready,
  input  logic [XLEN-1:0]          ref_pc,
  input  logic [REG_W-1:0]         ref_rd,
  input  logic [XLEN-1:0]          ref_wdata,
  input  logic                     end_req,
  output logic                     err_valid,
  output logic [XLEN-1:0]          err_dut_pc,
  output logic [XLEN-1:0]          err_ref_pc,
  output logic [REG_W-1:0]         err_dut_rd,
  output logic [REG_W-1:0]         err_ref_rd,
  output logic [XLEN-1:0]          err_dut_wdata,
  output logic [XLEN-1:0]          err_ref_wdata,
  output logic [15:0]              mismatch_cnt,
  output logic [31:0]              inst_cnt,
  output logic                     overflow,
  output logic                     done
`ifdef TRACE_CHK_HALT_ON_ERR_EN
  ,
  output logic                     halt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  chk_state_e                state_q, state_d;
  commit_entry_t [LANES-1:0] lane_entry;
  logic [LANES-1:0]          lane_push;
  commit_entry_t             head;
  commit_entry_t             ref_entry;
  logic [CNT_W-1:0]          fifo_count;
  logic [CNT_W-1:0]          unused_free;
  logic                      unused_full;
  logic                      fifo_drop;
  logic                      run, pop, is_end, skip, mism_c, end_c;

  assign run = (state_q == RUN);

  // Lanes with rd==0 retire but never reach the comparison FIFO.
  always_comb begin
    lane_entry = '0;
    lane_push  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_entry[i].pc    = wb_pc[i*XLEN +: XLEN];
      lane_entry[i].rd    = wb_rd[i*REG_W +: REG_W];
      lane_entry[i].wdata = wb_wdata[i*XLEN +: XLEN];
      lane_push[i]        = run && wb_en[i] && (wb_rd[i*REG_W +: REG_W] != '0);
    end
  end

  trace_commit_fifo #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (lane_push),
    .wr_data  (lane_entry),
    .rd_en    (pop),
    .head_c   (head),
    .count    (fifo_count),
    .full_c   (unused_full),
    .free_c   (unused_free),
    .drop_c   (fifo_drop)
  );

  assign ref_entry = '{pc: ref_pc, rd: ref_rd, wdata: ref_wdata};
  assign ref_ready = run && (fifo_count != '0);
  assign pop       = ref_ready && ref_valid;
  assign is_end    = (ref_pc == END_PC);
  assign skip      = ((head.pc & SKIP_MASK) == SKIP_BASE);
  assign mism_c    = pop && !is_end && !skip && (head != ref_entry);
  assign end_c     = run && ((pop && is_end) || end_req);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (end_c) state_d = DONE;
`ifdef TRACE_CHK_HALT_ON_ERR_EN
        else if (mism_c && !err_valid) state_d = HALT;
`endif
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  assign done = (state_q == DONE);
`ifdef TRACE_CHK_HALT_ON_ERR_EN
  assign halt_o = (state_q == HALT);
`endif

  // Counters and first-error capture; everything holds outside RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      inst_cnt      <= '0;
      mismatch_cnt  <= '0;
      overflow      <= 1'b0;
      err_valid     <= 1'b0;
      err_dut_pc    <= '0;
      err_ref_pc    <= '0;
      err_dut_rd    <= '0;
      err_ref_rd    <= '0;
      err_dut_wdata <= '0;
      err_ref_wdata <= '0;
    end else if (run) begin
      inst_cnt <= inst_cnt + 32'(popcount(32'(wb_en)));
      if (fifo_drop) overflow <= 1'b1;
      if (mism_c) begin
        if (mismatch_cnt != 16'hffff) mismatch_cnt <= mismatch_cnt + 16'd1;
        if (!err_valid) begin
          err_valid     <= 1'b1;
          err_dut_pc    <= head.pc;
          err_ref_pc    <= ref_pc;
          err_dut_rd    <= head.rd;
          err_ref_rd    <= ref_rd;
          err_dut_wdata <= head.wdata;
          err_ref_wdata <= ref_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Scoreboard bench for commit_trace_checker: a queue-based trace model predicts
// every cycle's outputs; a monitor process compares them against the DUT.
module tb_commit_trace_checker;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] SKIP_BASE = 32'hbfc00380;
  localparam logic [31:0] SKIP_MASK = 32'hfffffff8;
  localparam logic [31:0] END_PC    = 32'hbfc00100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  wb_en = '0;
  logic [9:0]  wb_rd = '0;
  logic [63:0] wb_wdata = '0;
  logic [63:0] wb_pc = '0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [31:0] ref_pc = '0;
  logic [4:0]  ref_rd = '0;
  logic [31:0] ref_wdata = '0;
  logic        end_req = 1'b0;
  logic        err_valid;
  logic [31:0] err_dut_pc, err_ref_pc, err_dut_wdata, err_ref_wdata;
  logic [4:0]  err_dut_rd, err_ref_rd;
  logic [15:0] mismatch_cnt;
  logic [31:0] inst_cnt;
  logic        overflow;
  logic        done;
`ifdef TRACE_CHK_HALT_ON_ERR_EN
  logic        halt_o;
`endif

  always #5 clock = ~clock;

  commit_trace_checker #(
    .LANES(LANES), .DEPTH(DEPTH), .SKIP_BASE(SKIP_BASE), .SKIP_MASK(SKIP_MASK), .END_PC(END_PC)
  ) dut (
    .clock(clock), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .wb_pc(wb_pc), .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
    .ref_rd(ref_rd), .ref_wdata(ref_wdata), .end_req(end_req), .err_valid(err_valid),
    .err_dut_pc(err_dut_pc), .err_ref_pc(err_ref_pc), .err_dut_rd(err_dut_rd),
    .err_ref_rd(err_ref_rd), .err_dut_wdata(err_dut_wdata), .err_ref_wdata(err_ref_wdata),
    .mismatch_cnt(mismatch_cnt), .inst_cnt(inst_cnt), .overflow(overflow), .done(done)
`ifdef TRACE_CHK_HALT_ON_ERR_EN
    , .halt_o(halt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    bit          chk_ready;
    logic        exp_ready;
    logic        errv;
    logic [31:0] dpc, rpc, dwd, rwd;
    logic [4:0]  drd, rrd;
    logic [15:0] mism;
    logic [31:0] inst;
    logic        ovf, done, halt;
  } exp_t;

  exp_t sb[$];
  ent_t mq[$];

  // Reference model state: 0 = checking, 1 = finished, 2 = halted on error.
  int          m_state = 0;
  bit          m_init = 0;
  logic        m_errv = 0, m_ovf = 0;
  logic [31:0] m_dpc = 0, m_rpc = 0, m_dwd = 0, m_rwd = 0, m_inst = 0;
  logic [4:0]  m_drd = 0, m_rrd = 0;
  logic [15:0] m_mism = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input logic [1:0] en,
                      input logic [4:0] r0, input logic [4:0] r1,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input bit rv, input logic [31:0] rpc, input logic [4:0] rrd,
                      input logic [31:0] rwd, input bit ereq);
    exp_t e;
    ent_t h;
    ent_t lanes[2];
    int   free_slots, pushed;
    bit   fin, first_err;
    @(negedge clock);
    reset = rst; wb_en = en; wb_rd = {r1, r0}; wb_pc = {p1, p0}; wb_wdata = {d1, d0};
    ref_valid = rv; ref_pc = rpc; ref_rd = rrd; ref_wdata = rwd; end_req = ereq;
    e.chk_ready = m_init && !rst;
    e.exp_ready = (m_state == 0) && (mq.size() != 0);
    lanes[0] = '{pc: p0, rd: r0, wd: d0};
    lanes[1] = '{pc: p1, rd: r1, wd: d1};
    if (rst) begin
      m_init = 1; m_state = 0; mq.delete();
      m_errv = 0; m_ovf = 0; m_dpc = 0; m_rpc = 0; m_dwd = 0; m_rwd = 0;
      m_drd = 0; m_rrd = 0; m_mism = 0; m_inst = 0;
    end else if (m_state == 0) begin
      free_slots = DEPTH - mq.size();
      fin = ereq;
      first_err = 0;
      if (mq.size() != 0 && rv) begin
        h = mq.pop_front();
        if (rpc == END_PC) fin = 1;
        else if ((h.pc & SKIP_MASK) != SKIP_BASE &&
                 (h.pc != rpc || h.rd != rrd || h.wd != rwd)) begin
          if (m_mism != 16'hffff) m_mism = m_mism + 16'd1;
          if (!m_errv) begin
            m_errv = 1; first_err = 1;
            m_dpc = h.pc; m_drd = h.rd; m_dwd = h.wd;
            m_rpc = rpc; m_rrd = rrd; m_rwd = rwd;
          end
        end
      end
      pushed = 0;
      for (int i = 0; i < 2; i++) begin
        if (en[i] && lanes[i].rd != 0) begin
          if (pushed < free_slots) begin mq.push_back(lanes[i]); pushed++; end
          else m_ovf = 1;
        end
      end
      m_inst = m_inst + 32'($countones(en));
      if (fin) m_state = 1;
`ifdef TRACE_CHK_HALT_ON_ERR_EN
      else if (first_err) m_state = 2;
`endif
    end
    e.errv = m_errv; e.dpc = m_dpc; e.rpc = m_rpc; e.dwd = m_dwd; e.rwd = m_rwd;
    e.drd = m_drd; e.rrd = m_rrd; e.mism = m_mism; e.inst = m_inst; e.ovf = m_ovf;
    e.done = (m_state == 1); e.halt = (m_state == 2);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Retire lanes only (golden side idle).
  task automatic retire(input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] d0, input logic [31:0] d1);
    step(0, en, r0, r1, p0, p1, d0, d1, 0, 0, 0, 0, 0);
  endtask

  task automatic golden(input logic [31:0] rpc, input logic [4:0] rrd, input logic [31:0] rwd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, rpc, rrd, rwd, 0);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom % 4)
      0:       return 32'hbfc00000;
      1:       return 32'hbfc00004;
      2:       return 32'hbfc00384;
      default: return 32'hbfc00388;
    endcase
  endfunction

  // Monitor: ref_ready checked before the edge, registered outputs after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_ready) chk("ref_ready", 32'(ref_ready), 32'(e.exp_ready));
        @(posedge clock);
        #1;
        chk("err_valid", 32'(err_valid), 32'(e.errv));
        chk("err_dut_pc", err_dut_pc, e.dpc);
        chk("err_ref_pc", err_ref_pc, e.rpc);
        chk("err_dut_rd", 32'(err_dut_rd), 32'(e.drd));
        chk("err_ref_rd", 32'(err_ref_rd), 32'(e.rrd));
        chk("err_dut_wdata", err_dut_wdata, e.dwd);
        chk("err_ref_wdata", err_ref_wdata, e.rwd);
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mism));
        chk("inst_cnt", inst_cnt, e.inst);
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("done", 32'(done), 32'(e.done));
`ifdef TRACE_CHK_HALT_ON_ERR_EN
        chk("halt_o", 32'(halt_o), 32'(e.halt));
`endif
      end
    end
  end

  initial begin
    rst_cycle();
    idle(1);

    // Matching two-lane stream.
    retire(2'b11, 1, 2, 32'hbfc00000, 32'hbfc00004, 1, 2);
    golden(32'hbfc00000, 1, 1);
    golden(32'hbfc00004, 2, 2);
    idle(2);

    // Data mismatch, then a second mismatch that must not move err_*.
    retire(2'b11, 3, 3, 32'hbfc00010, 32'hbfc00014, 5, 7);
    golden(32'hbfc00010, 3, 6);
    golden(32'hbfc00014, 3, 8);
    idle(1);

    // Skip window with differing data.
    rst_cycle();
    retire(2'b11, 4, 0, 32'hbfc00384, 32'hbfc00388, 9, 3);
    golden(32'hbfc00384, 4, 10);
    idle(2);

    // rd==0 and overflow with the golden side stalled.
    rst_cycle();
    for (int i = 0; i < 3; i++)
      retire(2'b11, 1, 2, 32'h100 * i, 32'h100 * i + 4, i, i + 1);
    retire(2'b01, 0, 0, 32'h400, 0, 0, 0);
    idle(1);
    golden(32'h0, 1, 0);
    golden(32'h4, 2, 1);
    golden(32'h100, 1, 1);
    golden(32'h104, 2, 2);
    idle(1);

    // Termination by END_PC, then retirements after done.
    rst_cycle();
    retire(2'b01, 1, 0, 32'h40, 0, 1, 0);
    golden(END_PC, 7, 7);
    retire(2'b11, 1, 2, 32'h44, 32'h48, 3, 4);
    retire(2'b11, 1, 2, 32'h4c, 32'h50, 3, 4);
    golden(32'h44, 1, 3);

    // Termination by end_req.
    rst_cycle();
    retire(2'b11, 1, 2, 32'h60, 32'h64, 1, 2);
    step(0, 2'b01, 3, 0, 32'h68, 0, 5, 0, 0, 0, 0, 0, 1);
    retire(2'b11, 1, 2, 32'h6c, 32'h70, 1, 2);
    golden(32'h60, 1, 1);

    // Reset mid-run with queued entries and a captured error.
    rst_cycle();
    retire(2'b11, 1, 2, 32'h80, 32'h84, 1, 2);
    retire(2'b11, 3, 4, 32'h88, 32'h8c, 3, 4);
    golden(32'h80, 1, 9);
    rst_cycle();
    idle(2);

    // Randomized traffic with occasional resets, END_PC and end_req.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 250) == 0, 2'($urandom), 5'($urandom % 4), 5'($urandom % 4),
           pick_pc(), pick_pc(), 32'($urandom % 2), 32'($urandom % 2),
           ($urandom % 3) != 0, (($urandom % 150) == 0) ? END_PC : pick_pc(),
           5'($urandom % 4), 32'($urandom % 2), ($urandom % 400) == 0);
    end
    idle(2);

    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
